id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port instr_valid  input  1  instr/pc_in hold a valid fetched instruction.
REQ-004 SHALL have port instr  input  32  instruction word (op[31:26], rs[25:21], rt[20:16], rd[15:11], imm/funct[15:0]).
REQ-005 SHALL have port pc_in  input  32  PC of instr.
REQ-006 SHALL have port flush  input  1  taken branch from EX; kill the instruction in decode.
REQ-007 SHALL have ports wb_en  input  1, wb_addr  input  5, wb_data  input  32  register-file write-back.
REQ-008 SHALL have port stall_flag  output  1  load-use hazard; fetch and decode hold.
REQ-009 SHALL have registered ID/EX outputs: rs_val 32, rt_val 32, sign_ext 32, alu_src 1, alu_op 2, branch 1, mem_read 1, mem_write 1, reg_write 1, dest 5, pc_out 32, valid_out 1, illegal_op 1.

Function
REQ-010 SHALL decode opcodes: RTYPE 000000, LW 100011, SW 101011, ADDI 001000, BEQ 000100.
REQ-011 SHALL set alu_op 00 for LW/SW/ADDI, 01 for BEQ, 10 for RTYPE.
REQ-012 SHALL set alu_src 1 for LW/SW/ADDI, 0 otherwise; branch 1 only for BEQ; mem_read 1 only for LW; mem_write 1 only for SW.
REQ-013 SHALL set reg_write 1 and dest rd for RTYPE, dest rt for LW/ADDI; reg_write 0 and dest 0 for SW/BEQ.
REQ-014 SHALL compute sign_ext = sign extension of instr[15:0] (bit 15 replicated into [31:16]); funct travels in sign_ext[5:0].
REQ-015 SHALL contain a 32x32 register file; register 0 reads 0, writes to it ignored; write on rising clk when wb_en.
REQ-016 SHALL bypass write-back on read: same-cycle wb_en with wb_addr == source addr (nonzero) returns wb_data.
REQ-017 SHALL assert stall_flag combinationally when ID/EX holds valid_out=1, mem_read=1, dest!=0, and dest equals instr rs, or equals instr rt for RTYPE/SW/BEQ, while instr_valid=1.
REQ-018 SHALL, on a stall cycle, load a bubble (valid_out=0, all control bits 0, dest 0) into ID/EX; the stalled instruction is decoded again next cycle (upstream holds it).
REQ-019 SHALL, on flush, load a bubble regardless of stall; flush has priority; stall_flag is forced 0 when flush=1.
REQ-020 SHALL load a bubble when instr_valid=0.
REQ-021 SHALL, for an unknown opcode, load a bubble and set illegal_op=1 for exactly one cycle (registered with the bubble).
REQ-022 SHALL otherwise register decoded fields, rs_val, rt_val, pc_out=pc_in and valid_out=1 each rising clk; latency one cycle.

Reset
REQ-023 SHALL, while reset=1, clear all ID/EX outputs to 0 and all 32 registers to 0, independent of clk.
REQ-024 SHALL drive stall_flag 0 during reset and in the first cycle after release (ID/EX empty).
REQ-025 SHALL discard any in-progress decode on reset mid-operation; no write-back occurs during reset.

Structure
REQ-026 SHALL place opcode, alu_op, and funct constants (ADD 000000, SUB 000001, MUL 000010) in shared package cpu_pkg, used also by EX.
REQ-027 SHALL implement the register file as sub-module reg_file (two async read ports with bypass, one sync write port, async reset).

Verification
REQ-028 ADDI r1,r0,-4 (0x2001FFFC) -> next cycle: alu_op 00, alu_src 1, sign_ext 0xFFFFFFFC, dest 1, reg_write 1, valid_out 1.
REQ-029 wb_en=1 wb_addr=3 wb_data=0x55 same cycle as ADD r4,r3,r3 -> rs_val=rt_val=0x55; wb to r0 -> rs_val 0 on later read of r0.
REQ-030 LW r2,0(r1) followed by ADD r5,r2,r1 -> stall_flag 1 one cycle, bubble (valid_out 0) emitted, ADD emitted next cycle; LW r2 then ADDI r6,r7,1 -> no stall.
REQ-031 flush=1 with stall condition present -> stall_flag 0, bubble loaded; opcode 111111 -> bubble, illegal_op 1 for one cycle.
REQ-032 reset asserted mid-stream asynchronously -> all outputs 0 immediately; register r3 previously 0x55 reads 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU-op and funct constants plus opcode decode helper
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FUNCT_ADD = 6'b000000;
    localparam logic [5:0] FUNCT_SUB = 6'b000001;
    localparam logic [5:0] FUNCT_MUL = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic    legal;
        logic    uses_rt;   // rt is a source operand (hazard relevant)
        logic    rd_dest;   // destination comes from rd rather than rt
        logic    alu_src;
        alu_op_t alu_op;
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        c.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.legal = 1'b1; c.uses_rt = 1'b1; c.rd_dest = 1'b1;
                c.alu_op = ALU_FUNCT; c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.legal = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1;
            end
            OP_SW: begin
                c.legal = 1'b1; c.uses_rt = 1'b1; c.alu_src = 1'b1; c.mem_write = 1'b1;
            end
            OP_ADDI: begin
                c.legal = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
            end
            OP_BEQ: begin
                c.legal = 1'b1; c.uses_rt = 1'b1; c.alu_op = ALU_BRANCH; c.branch = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two async read ports with write-back bypass
module reg_file
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is hardwired; a same-cycle write-back is forwarded to the reader
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (wen && waddr == raddr_a) rdata_a = wdata;
        if (wen && waddr == raddr_b) rdata_b = wdata;
        if (raddr_a == 5'd0) rdata_a = '0;
        if (raddr_b == 5'd0) rdata_b = '0;
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: opcode decode, register read, load-use stall, ID/EX register
module id_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall_flag,
    output logic [31:0] rs_val,
    output logic [31:0] rt_val,
    output logic [31:0] sign_ext,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [4:0]  dest,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        illegal_op
);

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    ctrl_t       ctrl;
    logic [31:0] sext;
    logic [4:0]  dest_dec;
    logic [31:0] rs_rd, rt_rd;
    logic        hazard;
    logic        bubble;

    reg_file u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_rd),
        .rdata_b (rt_rd),
        .wen     (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    always_comb begin
        opcode   = instr[31:26];
        rs       = instr[25:21];
        rt       = instr[20:16];
        rd       = instr[15:11];
        ctrl     = decode_op(opcode);
        sext     = {{16{instr[15]}}, instr[15:0]};
        dest_dec = '0;
        if (ctrl.reg_write) dest_dec = ctrl.rd_dest ? rd : rt;
    end

    // load-use: the load in ID/EX produces a register this instruction reads
    always_comb begin
        hazard = valid_out && mem_read && dest != 5'd0 && instr_valid &&
                 (dest == rs || (ctrl.uses_rt && dest == rt));
        stall_flag = hazard && !flush;
        bubble = flush || !instr_valid || stall_flag || !ctrl.legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_val     <= '0;
            rt_val     <= '0;
            sign_ext   <= '0;
            alu_src    <= 1'b0;
            alu_op     <= 2'b00;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            dest       <= '0;
            pc_out     <= '0;
            valid_out  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (bubble) begin
            rs_val     <= '0;
            rt_val     <= '0;
            sign_ext   <= '0;
            alu_src    <= 1'b0;
            alu_op     <= 2'b00;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            dest       <= '0;
            pc_out     <= '0;
            valid_out  <= 1'b0;
            illegal_op <= instr_valid && !flush && !stall_flag && !ctrl.legal;
        end else begin
            rs_val     <= rs_rd;
            rt_val     <= rt_rd;
            sign_ext   <= sext;
            alu_src    <= ctrl.alu_src;
            alu_op     <= ctrl.alu_op;
            branch     <= ctrl.branch;
            mem_read   <= ctrl.mem_read;
            mem_write  <= ctrl.mem_write;
            reg_write  <= ctrl.reg_write;
            dest       <= dest_dec;
            pc_out     <= pc_in;
            valid_out  <= 1'b1;
            illegal_op <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_flag;
    logic [31:0] rs_val, rt_val, sign_ext, pc_out;
    logic        alu_src, branch, mem_read, mem_write, reg_write, valid_out, illegal_op;
    logic [1:0]  alu_op;
    logic [4:0]  dest;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc_in       (pc_in),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall_flag  (stall_flag),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .sign_ext    (sign_ext),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .dest        (dest),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .illegal_op  (illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0; pc_in = '0;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #2;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_stall", 32'(stall_flag), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rel_rs_val", rs_val, 0);
        chk("rel_regw", 32'(reg_write), 0);
        chk("rel_stall", 32'(stall_flag), 0);

        // seed r1=0x10, r7=0x20, r3=0x55 through write-back
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h10; step();
        wb_addr = 5'd7; wb_data = 32'h20; step();
        wb_addr = 5'd3; wb_data = 32'h55; step();
        wb_en = 1'b0;
        chk("idle_bubble", 32'(valid_out), 0);

        // ADDI r1,r0,-4
        instr_valid = 1'b1; instr = 32'h2001FFFC; pc_in = 32'h100; step();
        chk("addi_aluop", 32'(alu_op), 0);
        chk("addi_alusrc", 32'(alu_src), 1);
        chk("addi_sext", sign_ext, 32'hFFFFFFFC);
        chk("addi_dest", 32'(dest), 1);
        chk("addi_regw", 32'(reg_write), 1);
        chk("addi_valid", 32'(valid_out), 1);
        chk("addi_pc", pc_out, 32'h100);
        chk("addi_rt_val", rt_val, 32'h10);

        // ADD r4,r6,r6 with same-cycle write-back of r6 (bypass)
        instr = 32'h00C62000; pc_in = 32'h104;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h77;
        #1 chk("add_nostall", 32'(stall_flag), 0);
        step();
        wb_en = 1'b0;
        chk("byp_rs_val", rs_val, 32'h77);
        chk("byp_rt_val", rt_val, 32'h77);
        chk("add_aluop", 32'(alu_op), 2);
        chk("add_dest", 32'(dest), 4);
        chk("add_alusrc", 32'(alu_src), 0);

        // ADD r5,r0,r0 while writing r0: bypass must not apply, write ignored
        instr = 32'h00002800; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hAA; step();
        chk("r0_byp", rs_val, 0);
        wb_en = 1'b0; step();
        chk("r0_read", rs_val, 0);

        // SW r3,8(r1)
        instr = 32'hAC230008; step();
        chk("sw_memw", 32'(mem_write), 1);
        chk("sw_regw", 32'(reg_write), 0);
        chk("sw_dest", 32'(dest), 0);
        chk("sw_rt_val", rt_val, 32'h55);

        // BEQ r1,r7,-1
        instr = 32'h1027FFFF; step();
        chk("beq_branch", 32'(branch), 1);
        chk("beq_aluop", 32'(alu_op), 1);
        chk("beq_sext", sign_ext, 32'hFFFFFFFF);

        // LW r2,0(r1) then ADD r5,r2,r1: one stall cycle
        instr = 32'h8C220000; step();
        chk("lw_memr", 32'(mem_read), 1);
        chk("lw_dest", 32'(dest), 2);
        instr = 32'h00412800;
        #1 chk("lu_stall", 32'(stall_flag), 1);
        step();
        chk("lu_bubble", 32'(valid_out), 0);
        chk("lu_bub_dest", 32'(dest), 0);
        chk("lu_stall_gone", 32'(stall_flag), 0);
        step();
        chk("lu_add_valid", 32'(valid_out), 1);
        chk("lu_add_dest", 32'(dest), 5);
        chk("lu_add_rt", rt_val, 32'h10);

        // LW r2 then ADDI r6,r7,1: no dependency
        instr = 32'h8C220000; step();
        instr = 32'h20E60001;
        #1 chk("addi_nostall", 32'(stall_flag), 0);
        step();
        chk("addi2_valid", 32'(valid_out), 1);
        chk("addi2_rs", rs_val, 32'h20);

        // flush overrides stall
        instr = 32'h8C220000; step();
        instr = 32'h00412800; flush = 1'b1;
        #1 chk("flush_stall", 32'(stall_flag), 0);
        step();
        flush = 1'b0;
        chk("flush_bubble", 32'(valid_out), 0);

        // illegal opcode
        instr = 32'hFC000000; step();
        chk("ill_flag", 32'(illegal_op), 1);
        chk("ill_valid", 32'(valid_out), 0);
        instr_valid = 1'b0; step();
        chk("ill_once", 32'(illegal_op), 0);

        // async reset mid-stream
        instr_valid = 1'b1; instr = 32'h00632000; pc_in = 32'h200; step();
        chk("pre_rst_rs", rs_val, 32'h55);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_out), 0);
        chk("arst_rs", rs_val, 0);
        chk("arst_pc", pc_out, 0);
        step();
        reset = 1'b0;
        chk("post_rst_stall", 32'(stall_flag), 0);
        step();
        chk("r3_cleared", rs_val, 0);
        chk("post_rst_valid", 32'(valid_out), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
